bcd_count_sequencer: RTL and testbench
======================================

// Module: bcd_count_sequencer
// PURPOSE
//  Run/pause/clear controller for the 2-digit BCD counter (units 0-9, tens 0-5).
//  - Converts button commands into a one-cycle count-enable strobe, paced by an internal prescaler.
//  - Issues a clear pulse to the counter.
//  - Watches the counter's digits and stops the count at a programmable BCD limit.
//  - Sits between the user-input debounce logic and the counter's start/reset-side controls.
// PARAMETERS
//  DIV      default 50_000_000  clk cycles per count step; legal range >= 1
//  PRE_W    default $clog2(DIV)>0 ? $clog2(DIV) : 1   prescaler width (derived, do not override)
// PORTS
//  clk          in   1  clock; all state updates on the rising edge
//  reset        in   1  asynchronous, active-high reset
//  btn_start    in   1  level command, synchronous; start or resume
//  btn_stop     in   1  level command, synchronous; pause
//  btn_clear    in   1  level command, synchronous; abort and zero the counter
//  limit_units  in   4  BCD terminal units digit; sampled on IDLE->RUN
//  limit_tens   in   4  BCD terminal tens digit; sampled on IDLE->RUN
//  cnt_units    in   4  current counter units digit (registered output of counter)
//  cnt_tens     in   4  current counter tens digit
//  cnt_en       out  1  one-cycle count strobe, drives the counter's count-enable
//  cnt_clr      out  1  one-cycle synchronous clear request to the counter
//  running      out  1  state==RUN
//  paused       out  1  state==PAUSE
//  done         out  1  state==DONE
//  done_pulse   out  1  one cycle high on the clock edge that enters DONE
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, limit regs=00; all outputs 0.
//  States: IDLE, RUN, PAUSE, DONE. Command priority every cycle is clear > stop > start.
//  IDLE:
//   - clear: cnt_clr=1 for that cycle; stay in IDLE.
//   - start: latch the limit, clamped per digit (units>9 -> 9, tens>5 -> 5); prescaler=0; go to RUN.
//  RUN:
//   - clear: go to IDLE, cnt_clr=1, prescaler=0.
//   - stop: go to PAUSE; prescaler holds its value.
//   - at_limit = ({cnt_tens,cnt_units} == latched limit). If at_limit: go to DONE, cnt_en=0.
//   - Otherwise prescaler counts 0..DIV-1 and wraps to 0.
//   - cnt_en = RUN && prescaler==DIV-1 && !at_limit && !stop && !clear.
//   - cnt_en is a combinational decode of registered state only; no input-to-output path except the gating terms above.
//   - The counter updates on the edge where cnt_en=1; the new value is compared from the next cycle on.
//  PAUSE:
//   - clear: go to IDLE with cnt_clr=1.
//   - start (stop low): go to RUN; prescaler resumes from its held value.
//   - cnt_en=0 throughout.
//  DONE:
//   - done=1; start and stop are ignored.
//   - clear: go to IDLE with cnt_clr=1.
//  done_pulse is registered; it is high in the first cycle that state==DONE.
//  Limit 00 with the counter at 00: IDLE->RUN, then DONE on the next edge; zero cnt_en strobes.
//  Commands are level-sensitive. Holding start in RUN has no effect.
//  DIV=1: cnt_en is high every RUN cycle that is not at the limit.
//  Reset mid-operation: immediate return to the reset values; no cnt_clr is issued (the counter shares reset).
// STRUCTURE
//  Package bcd_ctrl_pkg holds:
//   - typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} seq_state_t
//   - localparams BCD_MAX_UNITS=4'd9, BCD_MAX_TENS=4'd5
//   - function bcd_clamp(digit, max)
//  Sub-module bcd_tick_prescaler (DIV):
//   - ports: clk, reset, en, clr, tick
//   - tick is a decode of count==DIV-1
//  The FSM, limit registers and compare live in this module.
// TESTING (DIV=4, counter instance connected, start=cnt_en, digits fed back)
//  1. limit=03, start pulse.
//     -> cnt_en high in RUN cycles 4, 8 and 12; counter reads 01, 02, 03.
//     -> done and done_pulse one cycle after 03 is seen; no fourth strobe.
//  2. limit=05; stop held 2 cycles after RUN cycle 2, then start.
//     -> paused=1; prescaler resumes at 2; the next cnt_en arrives 2 RUN cycles later.
//  3. In RUN with the counter at 02: clear, stop and start all high together.
//     -> IDLE, cnt_clr=1 for one cycle, counter reads 00, no cnt_en.
//  4. limit=7F (invalid BCD).
//     -> clamped to 59; run to completion; done when the counter reads 59; no wrap to 00.
//  5. limit=00, counter at 00, start.
//     -> RUN for one cycle, then DONE; zero cnt_en strobes; done_pulse once.
//  6. Assert reset mid-RUN (prescaler=2).
//     -> all outputs 0 asynchronously; after release a start restarts the prescaler at 0.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD counter run/pause/clear controller.
package bcd_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} seq_state_t;

   localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

   // Saturate a digit so an out-of-range limit can still be reached by the counter.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] digit, input logic [3:0] max);
      return (digit > max) ? max : digit;
   endfunction

endpackage

// File: rtl/bcd_tick_prescaler.sv
// Free-running divide-by-DIV prescaler; tick marks the last count of each period.
module bcd_tick_prescaler #(
   parameter int DIV   = 50_000_000,
   parameter int PRE_W = ($clog2(DIV) > 0) ? $clog2(DIV) : 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= (count == LAST) ? '0 : count + PRE_W'(1);
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/bcd_count_sequencer.sv
// Run/pause/clear sequencer for the 2-digit BCD counter: paces count strobes,
// issues clear requests and stops the count at a latched BCD limit.
module bcd_count_sequencer
   import bcd_ctrl_pkg::*;
#(
   parameter int DIV   = 50_000_000,
   parameter int PRE_W = ($clog2(DIV) > 0) ? $clog2(DIV) : 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_stop,
   input  logic       btn_clear,
   input  logic [3:0] limit_units,
   input  logic [3:0] limit_tens,
   input  logic [3:0] cnt_units,
   input  logic [3:0] cnt_tens,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       running,
   output logic       paused,
   output logic       done,
   output logic       done_pulse
);

   seq_state_t state;
   logic [3:0] lim_units;
   logic [3:0] lim_tens;
   logic       at_limit;
   logic       advance;
   logic       pre_clr;
   logic       tick;

   // Advance only when nothing overrides the run this cycle.
   always_comb begin
      at_limit = ({cnt_tens, cnt_units} == {lim_tens, lim_units});
      advance  = (state == RUN) && !btn_clear && !btn_stop && !at_limit;
      pre_clr  = (state == IDLE) || btn_clear;
      cnt_en   = advance && tick;
      cnt_clr  = btn_clear && !reset;
   end

   bcd_tick_prescaler #(.DIV(DIV), .PRE_W(PRE_W)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (advance),
      .clr   (pre_clr),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         lim_units  <= 4'd0;
         lim_tens   <= 4'd0;
         done_pulse <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (!btn_clear && !btn_stop && btn_start) begin
                  lim_units <= bcd_clamp(limit_units, BCD_MAX_UNITS);
                  lim_tens  <= bcd_clamp(limit_tens, BCD_MAX_TENS);
                  state     <= RUN;
               end
            end
            RUN: begin
               if (btn_clear)
                  state <= IDLE;
               else if (btn_stop)
                  state <= PAUSE;
               else if (at_limit) begin
                  state      <= DONE;
                  done_pulse <= 1'b1;
               end
            end
            PAUSE: begin
               if (btn_clear)
                  state <= IDLE;
               else if (!btn_stop && btn_start)
                  state <= RUN;
            end
            DONE: begin
               if (btn_clear)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign running = (state == RUN);
   assign paused  = (state == PAUSE);
   assign done    = (state == DONE);

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Directed bench: sequencer with DIV=4 driving a behavioural 00..59 BCD counter.
module tb_bcd_count_sequencer;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_start, btn_stop, btn_clear;
   logic [3:0] limit_units, limit_tens;
   logic [3:0] cnt_units, cnt_tens;
   logic       cnt_en, cnt_clr, running, paused, done, done_pulse;

   int n_checks = 0;
   int n_fail   = 0;
   int strobes  = 0;

   always #5 clk = ~clk;

   bcd_count_sequencer #(.DIV(DIV)) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_start   (btn_start),
      .btn_stop    (btn_stop),
      .btn_clear   (btn_clear),
      .limit_units (limit_units),
      .limit_tens  (limit_tens),
      .cnt_units   (cnt_units),
      .cnt_tens    (cnt_tens),
      .cnt_en      (cnt_en),
      .cnt_clr     (cnt_clr),
      .running     (running),
      .paused      (paused),
      .done        (done),
      .done_pulse  (done_pulse)
   );

   // Counter under control: units 0-9, tens 0-5, shares the reset.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_units <= 4'd0;
         cnt_tens  <= 4'd0;
      end else if (cnt_clr) begin
         cnt_units <= 4'd0;
         cnt_tens  <= 4'd0;
      end else if (cnt_en) begin
         if (cnt_units == 4'd9) begin
            cnt_units <= 4'd0;
            cnt_tens  <= (cnt_tens == 4'd5) ? 4'd0 : cnt_tens + 4'd1;
         end else begin
            cnt_units <= cnt_units + 4'd1;
         end
      end
   end

   always @(posedge clk) if (cnt_en) strobes <= strobes + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] outs();
      return {cnt_en, cnt_clr, running, paused, done, done_pulse};
   endfunction

   function automatic logic [7:0] cnt();
      return {cnt_tens, cnt_units};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [12:0] mask13;
      logic [3:0]  mask4;
      int          s0;
      int          runc;

      reset = 1'b1;
      btn_start = 1'b0; btn_stop = 1'b0; btn_clear = 1'b0;
      limit_units = 4'd0; limit_tens = 4'd0;
      #12;
      check("reset_outs", 32'(outs()), 32'h0);
      check("reset_cnt", 32'(cnt()), 32'h00);
      reset = 1'b0;
      tick();

      // 1: limit 03, strobes at RUN cycles 4, 8, 12
      limit_tens = 4'd0; limit_units = 4'd3;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      check("t1_running", 32'(running), 32'h1);
      for (int rc = 1; rc <= 13; rc++) begin
         #1;
         mask13[rc-1] = cnt_en;
         if (rc == 9) check("t1_cnt_rc9", 32'(cnt()), 32'h02);
         tick();
      end
      check("t1_en_mask", 32'(mask13), 32'h888);
      check("t1_cnt_final", 32'(cnt()), 32'h03);
      check("t1_done_entry", 32'({running, done, done_pulse}), 32'b011);
      s0 = strobes;
      repeat (5) tick();
      check("t1_done_hold", 32'({done, done_pulse}), 32'b10);
      check("t1_no_4th", 32'(strobes - s0), 32'h0);
      check("t1_cnt_held", 32'(cnt()), 32'h03);
      btn_clear = 1'b1;
      #1;
      check("t1_clr_pulse", 32'(cnt_clr), 32'h1);
      tick();
      btn_clear = 1'b0;
      #1;
      check("t1_idle_outs", 32'(outs()), 32'h0);
      check("t1_cnt_zero", 32'(cnt()), 32'h00);

      // 2: limit 05, pause after RUN cycle 2, resume from prescaler=2
      limit_units = 4'd5;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      tick();
      tick();
      btn_stop = 1'b1;
      #1;
      check("t2_stop_no_en", 32'(cnt_en), 32'h0);
      tick();
      check("t2_paused1", 32'({running, paused}), 32'b01);
      tick();
      check("t2_paused2", 32'({running, paused, cnt_en}), 32'b010);
      btn_stop = 1'b0;
      btn_start = 1'b1;
      #1;
      check("t2_pause_no_en", 32'(cnt_en), 32'h0);
      tick();
      btn_start = 1'b0;
      #1;
      check("t2_resume_c1", 32'({running, cnt_en}), 32'b10);
      tick();
      check("t2_resume_c2", 32'({running, cnt_en}), 32'b11);
      tick();
      check("t2_cnt_01", 32'(cnt()), 32'h01);
      repeat (4) tick();
      check("t2_cnt_02", 32'(cnt()), 32'h02);

      // 3: clear, stop and start together in RUN
      btn_clear = 1'b1; btn_stop = 1'b1; btn_start = 1'b1;
      #1;
      check("t3_all_cmd", 32'({cnt_en, cnt_clr}), 32'b01);
      s0 = strobes;
      tick();
      btn_clear = 1'b0; btn_stop = 1'b0; btn_start = 1'b0;
      #1;
      check("t3_idle_outs", 32'(outs()), 32'h0);
      check("t3_cnt_zero", 32'(cnt()), 32'h00);
      check("t3_no_en", 32'(strobes - s0), 32'h0);

      // 4: limit 7F clamps to 59
      limit_tens = 4'h7; limit_units = 4'hF;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      s0 = strobes;
      runc = 0;
      while (!done && runc < 400) begin
         if (running) runc++;
         tick();
      end
      check("t4_done", 32'(done), 32'h1);
      check("t4_run_cycles", 32'(runc), 32'd237);
      check("t4_strobes", 32'(strobes - s0), 32'd59);
      check("t4_cnt_59", 32'(cnt()), 32'h59);
      repeat (10) tick();
      check("t4_no_wrap", 32'({done, 4'h0, cnt()}), 32'h1059);
      btn_clear = 1'b1;
      tick();
      btn_clear = 1'b0;
      check("t4_cnt_zero", 32'(cnt()), 32'h00);

      // 5: limit 00 with counter at 00
      limit_tens = 4'd0; limit_units = 4'd0;
      s0 = strobes;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      check("t5_run_once", 32'({running, cnt_en}), 32'b10);
      tick();
      check("t5_done_entry", 32'({running, done, done_pulse}), 32'b011);
      tick();
      check("t5_pulse_once", 32'({done, done_pulse}), 32'b10);
      check("t5_no_strobes", 32'(strobes - s0), 32'h0);
      btn_clear = 1'b1;
      tick();
      btn_clear = 1'b0;

      // 6: asynchronous reset mid-RUN with prescaler at 2
      limit_units = 4'd5;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      tick();
      tick();
      check("t6_pre_reset_run", 32'(running), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("t6_async_outs", 32'(outs()), 32'h0);
      #2 reset = 1'b0;
      tick();
      check("t6_idle_after", 32'(outs()), 32'h0);
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      for (int rc = 1; rc <= 4; rc++) begin
         #1;
         mask4[rc-1] = cnt_en;
         tick();
      end
      check("t6_restart_mask", 32'(mask4), 32'b1000);
      check("t6_cnt_01", 32'(cnt()), 32'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
